// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared FIFO constants for the read- and write-side pointer controllers.
//   P_SIZE_DEF   : default pointer width (one wrap bit above the address)
//   AE_LEVEL_DEF : default almost-empty threshold in entries
//   FIFO_DEPTH   : storage depth for the default pointer width
package fifo_rd_ctrl_pkg;

  localparam int unsigned P_SIZE_DEF   = 4;
  localparam int unsigned AE_LEVEL_DEF = 1;
  localparam int unsigned FIFO_DEPTH   = 2 ** (P_SIZE_DEF - 1);

  // Depth for an arbitrary pointer width; the extra MSB only tells full from empty.
  function automatic int unsigned fifo_depth(input int unsigned p_size);
    return 2 ** (p_size - 1);
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bus between the read-pointer controller and its user.
//   rinc          : read request, one entry per asserted cycle
//   wq2_wptr_gray : Gray write pointer, already synchronized into the read clock
//   raddr         : read address into the FIFO memory
//   rptr_gray     : registered Gray read pointer for the write-side synchronizer
//   rempty        : FIFO empty (registered)
//   ralmost_empty : occupancy at or below the almost-empty threshold (registered)
//   rcount        : read-side occupancy (registered)
//   runderflow    : one-cycle pulse for a read request made while empty
// master = FIFO reader / pointer source, slave = fifo_rd_ctrl.
interface fifo_rd_ctrl_if
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned P_SIZE = P_SIZE_DEF
);

  logic              rinc;
  logic [P_SIZE-1:0] wq2_wptr_gray;
  logic [P_SIZE-2:0] raddr;
  logic [P_SIZE-1:0] rptr_gray;
  logic              rempty;
  logic              ralmost_empty;
  logic [P_SIZE-1:0] rcount;
  logic              runderflow;

  modport master (
    output rinc,
    output wq2_wptr_gray,
    input  raddr,
    input  rptr_gray,
    input  rempty,
    input  ralmost_empty,
    input  rcount,
    input  runderflow
  );

  modport slave (
    input  rinc,
    input  wq2_wptr_gray,
    output raddr,
    output rptr_gray,
    output rempty,
    output ralmost_empty,
    output rcount,
    output runderflow
  );

endinterface

// File: rtl/fifo_rd_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter, shared by both FIFO pointer controllers.
//   gray_i : Gray-coded pointer
//   bin_o  : equivalent binary pointer
module gray2bin
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned P_SIZE = P_SIZE_DEF
) (
  input  logic [P_SIZE-1:0] gray_i,
  output logic [P_SIZE-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < P_SIZE; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller of an asynchronous FIFO.
//   Rclk   : read-domain clock
//   Rrst_n : asynchronous active-low reset
//   rd_if  : read-side bus (slave modport), see fifo_rd_ctrl_if
// Keeps a binary read pointer, publishes its Gray form to the write domain,
// and derives empty / almost-empty / occupancy / underflow from the already
// synchronized Gray write pointer. No synchronizer flops live here.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned P_SIZE   = P_SIZE_DEF,
  parameter int unsigned AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic          Rclk,
  input  logic          Rrst_n,
  fifo_rd_ctrl_if.slave rd_if
);

  logic [P_SIZE-1:0] rbin_q, rbin_d;
  logic [P_SIZE-1:0] rgray_q, rgray_d;
  logic [P_SIZE-1:0] rcount_q, count_d;
  logic [P_SIZE-1:0] wbin_sync;
  logic              rempty_q, rempty_d;
  logic              ralmost_q, ralmost_d;
  logic              runderflow_q, runderflow_d;
  logic              rd_en;

  gray2bin #(
    .P_SIZE (P_SIZE)
  ) u_gray2bin (
    .gray_i (rd_if.wq2_wptr_gray),
    .bin_o  (wbin_sync)
  );

  always_comb begin
    rd_en        = rd_if.rinc & ~rempty_q;
    rbin_d       = rbin_q + {{(P_SIZE-1){1'b0}}, rd_en};
    rgray_d      = rbin_d ^ (rbin_d >> 1);
    // Modulo subtraction also covers the full case where only the MSBs differ.
    count_d      = wbin_sync - rbin_d;
    rempty_d     = (rgray_d == rd_if.wq2_wptr_gray);
    ralmost_d    = (32'(count_d) <= 32'(AE_LEVEL));
    runderflow_d = rd_if.rinc & rempty_q;
  end

  always_ff @(posedge Rclk or negedge Rrst_n) begin
    if (!Rrst_n) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rcount_q     <= '0;
      rempty_q     <= 1'b1;
      ralmost_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      rcount_q     <= count_d;
      rempty_q     <= rempty_d;
      ralmost_q    <= ralmost_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign rd_if.raddr         = rbin_q[P_SIZE-2:0];
  assign rd_if.rptr_gray     = rgray_q;
  assign rd_if.rempty        = rempty_q;
  assign rd_if.ralmost_empty = ralmost_q;
  assign rd_if.rcount        = rcount_q;
  assign rd_if.runderflow    = runderflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Testbench for fifo_rd_ctrl (P_SIZE=4, AE_LEVEL=1).
module tb_fifo_rd_ctrl;

  localparam int P   = 4;
  localparam int AE  = 1;
  localparam int DEP = 8;

  logic Rclk;
  logic Rrst_n;
  int   wcnt;       // total entries ever written (unbounded)
  bit   chk_en;

  int n_checks;
  int n_fail;

  // Model: counts of reads done and writes seen by the read domain.
  int m_r;
  int m_w;
  bit m_uf;

  fifo_rd_ctrl_if #(.P_SIZE(P)) rif ();

  fifo_rd_ctrl #(
    .P_SIZE   (P),
    .AE_LEVEL (AE)
  ) dut (
    .Rclk   (Rclk),
    .Rrst_n (Rrst_n),
    .rd_if  (rif.slave)
  );

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  assign rif.wq2_wptr_gray = gray4(wcnt);

  initial begin
    Rclk = 1'b0;
    forever #5 Rclk = ~Rclk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour in terms of entry counts, not pointers.
  always @(posedge Rclk or negedge Rrst_n) begin
    if (!Rrst_n) begin
      m_r  <= 0;
      m_w  <= 0;
      m_uf <= 1'b0;
    end else begin
      m_uf <= rif.rinc && (m_w - m_r == 0);
      if (rif.rinc && (m_w - m_r > 0)) m_r <= m_r + 1;
      m_w <= wcnt;
    end
  end

  always @(negedge Rclk) begin
    if (chk_en) begin
      chk("m_raddr",  32'(rif.raddr),         32'(m_r % DEP));
      chk("m_rptr",   32'(rif.rptr_gray),     32'(gray4(m_r)));
      chk("m_rempty", 32'(rif.rempty),        32'((m_w - m_r) == 0));
      chk("m_rcount", 32'(rif.rcount),        32'(m_w - m_r));
      chk("m_almost", 32'(rif.ralmost_empty), 32'((m_w - m_r) <= AE));
      chk("m_uflow",  32'(rif.runderflow),    32'(m_uf));
    end
  end

  task automatic tick();
    @(negedge Rclk);
  endtask

  task automatic do_reset();
    Rrst_n   = 1'b0;
    rif.rinc = 1'b0;
    wcnt     = 0;
    tick();
    Rrst_n   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    Rrst_n   = 1'b0;
    rif.rinc = 1'b0;
    wcnt     = 0;
    tick();
    tick();
    // Reset state
    chk("rst_raddr",  32'(rif.raddr), 0);
    chk("rst_rptr",   32'(rif.rptr_gray), 0);
    chk("rst_empty",  32'(rif.rempty), 1);
    chk("rst_almost", 32'(rif.ralmost_empty), 1);
    chk("rst_count",  32'(rif.rcount), 0);
    chk("rst_uflow",  32'(rif.runderflow), 0);
    chk_en = 1'b1;
    Rrst_n = 1'b1;
    tick();
    chk("rel_uflow", 32'(rif.runderflow), 0);

    // Single write then single read
    wcnt = 1;
    tick();
    chk("sr_empty",  32'(rif.rempty), 0);
    chk("sr_count",  32'(rif.rcount), 1);
    chk("sr_almost", 32'(rif.ralmost_empty), 1);
    rif.rinc = 1'b1;
    tick();
    rif.rinc = 1'b0;
    chk("sr_raddr", 32'(rif.raddr), 1);
    chk("sr_rptr",  32'(rif.rptr_gray), 32'h1);
    chk("sr_empty2", 32'(rif.rempty), 1);
    chk("sr_count2", 32'(rif.rcount), 0);

    // Underflow from a fresh reset
    do_reset();
    tick();
    rif.rinc = 1'b1;
    tick();
    chk("uf_1", 32'(rif.runderflow), 1);
    tick();
    chk("uf_2", 32'(rif.runderflow), 1);
    chk("uf_raddr", 32'(rif.raddr), 0);
    rif.rinc = 1'b0;
    tick();
    chk("uf_end", 32'(rif.runderflow), 0);
    chk("uf_count", 32'(rif.rcount), 0);

    // Full FIFO, drain, then a second lap across the pointer wrap
    wcnt = 8;
    tick();
    chk("full_count",  32'(rif.rcount), 8);
    chk("full_almost", 32'(rif.ralmost_empty), 0);
    rif.rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("lap1_raddr", 32'(rif.raddr), 32'(i));
      tick();
    end
    rif.rinc = 1'b0;
    chk("lap1_end_raddr", 32'(rif.raddr), 0);
    chk("lap1_end_rptr",  32'(rif.rptr_gray), 32'hC);
    chk("lap1_end_empty", 32'(rif.rempty), 1);
    wcnt = 16;
    tick();
    chk("lap2_count", 32'(rif.rcount), 8);
    rif.rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("lap2_raddr", 32'(rif.raddr), 32'(i));
      tick();
    end
    rif.rinc = 1'b0;
    chk("lap2_end_raddr", 32'(rif.raddr), 0);
    chk("lap2_end_rptr",  32'(rif.rptr_gray), 0);
    chk("lap2_end_empty", 32'(rif.rempty), 1);

    // Simultaneous read and write
    wcnt = 19;
    tick();
    chk("sim_count0", 32'(rif.rcount), 3);
    rif.rinc = 1'b1;
    wcnt = 20;
    tick();
    rif.rinc = 1'b0;
    chk("sim_count", 32'(rif.rcount), 3);
    chk("sim_empty", 32'(rif.rempty), 0);

    // Asynchronous reset mid-stream
    wcnt = 22;
    tick();
    chk("mr_count0", 32'(rif.rcount), 5);
    #2;
    Rrst_n = 1'b0;
    #1;
    chk("ar_raddr",  32'(rif.raddr), 0);
    chk("ar_rptr",   32'(rif.rptr_gray), 0);
    chk("ar_empty",  32'(rif.rempty), 1);
    chk("ar_almost", 32'(rif.ralmost_empty), 1);
    chk("ar_count",  32'(rif.rcount), 0);
    chk("ar_uflow",  32'(rif.runderflow), 0);
    wcnt = 0;
    tick();
    Rrst_n = 1'b1;
    wcnt = 2;
    tick();
    chk("post_count", 32'(rif.rcount), 2);
    chk("post_uflow", 32'(rif.runderflow), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter P_SIZE, default 4: pointer width; FIFO depth = 2^(P_SIZE-1), default 8.
REQ-002 SHALL have parameter AE_LEVEL, default 1: almost-empty threshold in entries.
REQ-003 Rclk  input  1  read-domain clock; all state on rising edge.
REQ-004 Rrst_n  input  1  asynchronous, active-low reset.
REQ-005 rinc  input  1  read request, one entry per asserted cycle.
REQ-006 wq2_wptr_gray  input  P_SIZE  Gray write pointer, already two-flop synchronized into Rclk.
REQ-007 raddr  output  P_SIZE-1  read address to the FIFO memory.
REQ-008 rptr_gray  output  P_SIZE  registered Gray read pointer, sent to the write domain through a two-flop synchronizer.
REQ-009 rempty  output  1  FIFO empty, registered.
REQ-010 ralmost_empty  output  1  occupancy <= AE_LEVEL, registered.
REQ-011 rcount  output  P_SIZE  read-side occupancy, range 0..2^(P_SIZE-1), registered.
REQ-012 runderflow  output  1  single-cycle pulse, rinc while empty.

Function
REQ-013 Internal binary read pointer rbin (P_SIZE bits) SHALL advance when rd_en = rinc & ~rempty.
REQ-014 rbin_next = rbin + rd_en, modulo 2^P_SIZE; wrap from all-ones to zero is legal.
REQ-015 raddr SHALL equal rbin[P_SIZE-2:0], valid in the cycle rinc is sampled (no added latency).
REQ-016 rptr_gray SHALL be registered as rbin_next ^ (rbin_next >> 1), one Gray bit change per read.
REQ-017 rempty SHALL register (Gray(rbin_next) == wq2_wptr_gray).
REQ-018 wbin_sync SHALL be the combinational Gray-to-binary conversion of wq2_wptr_gray.
REQ-019 rcount SHALL register (wbin_sync - rbin_next) modulo 2^P_SIZE.
REQ-020 rcount SHALL be 0 exactly when rempty is 1, in every cycle.
REQ-021 ralmost_empty SHALL register (count_next <= AE_LEVEL).
REQ-022 rinc while rempty=1: pointer, raddr, and rptr_gray SHALL hold; runderflow SHALL be 1 on the next cycle only.
REQ-023 A read and a write-pointer advance in the same cycle SHALL leave rcount unchanged and rempty at 0.
REQ-024 Write pointer movement SHALL be visible on rempty/rcount one Rclk after wq2_wptr_gray changes.
REQ-025 Full-FIFO reading SHALL be correct: wbin_sync - rbin = depth, MSB difference handled by modulo arithmetic.

Reset
REQ-026 On Rrst_n low, asynchronously: rbin=0, rptr_gray=0, rempty=1, ralmost_empty=1, rcount=0, runderflow=0.
REQ-027 Reset asserted mid-operation SHALL discard pointer state immediately; the first edge after release SHALL behave as REQ-026 state.
REQ-028 Reset release SHALL not generate a runderflow pulse.

Structure
REQ-029 The shared FIFO package SHALL hold the default P_SIZE and AE_LEVEL and the depth constant 2^(P_SIZE-1).
REQ-030 Gray-to-binary conversion SHALL be one sub-module, gray2bin, parameterized by P_SIZE, reused by the write-side controller.
REQ-031 No other sub-modules; no synchronizer flops inside this block.

Verification (P_SIZE=4, AE_LEVEL=1)
REQ-032 Reset: all outputs per REQ-026; raddr=0.
REQ-033 Single read: wq2 0000->0001 -> next edge rempty=0, rcount=1, ralmost_empty=1. Then rinc for 1 cycle -> raddr 0->1, rptr_gray=0001, rempty=1, rcount=0.
REQ-034 Underflow: rinc=1 for 2 cycles with rempty=1 -> raddr stays 0, runderflow high 2 cycles (one per request), rcount=0.
REQ-035 Full and wrap: wq2=1100 (wbin 8) -> rcount=8. Then 8 back-to-back reads -> raddr 0..7 then 0, rptr_gray=1100, rempty=1. Then a second lap to wq2=0000 (wbin 16 mod 16) -> raddr wraps correctly.
REQ-036 Simultaneous: rcount=3, rinc=1 while wq2 advances by one -> rcount stays 3, rempty=0.
REQ-037 Reset mid-stream: rcount=5, Rrst_n pulsed low -> outputs at REQ-026 values within the same cycle, with no Rclk edge required.
